// File: rtl/core_sequencer_if.sv
// Control bus between the multi-cycle sequencer and the RV32 datapath/memories.
interface core_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    // Datapath / memory to sequencer
    logic             run;
    logic             imem_ack;
    logic             dmem_ack;
    logic             is_load;
    logic             is_store;
    logic             reg_write;
    logic             ecall_break;
    // Sequencer to datapath / memory
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic             pc_we;
    logic             halted;
    logic             bus_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] instret;

    // Sequencer side
    modport master (
        input  run, imem_ack, dmem_ack, is_load, is_store, reg_write, ecall_break,
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, bus_err,
               state, cycles, instret
    );

    // Datapath side
    modport slave (
        output run, imem_ack, dmem_ack, is_load, is_store, reg_write, ecall_break,
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted, bus_err,
               state, cycles, instret
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/MEM/WB sequencing with memory
// req/ack handshakes, halt on ecall/ebreak, timeout trap, and debug counters.
// Strobes are decoded from the registered state plus the current inputs so
// that ir_we can fire in the same cycle as imem_ack.
module core_sequencer #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_l,
    core_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   cycles_q;
    logic [CNT_W-1:0]   instret_q;

    logic               imem_req_c;
    logic               ir_we_c;
    logic               dmem_req_c;
    logic               dmem_we_c;
    logic               rf_we_c;
    logic               pc_we_c;
    logic               tmo_hit_c;
    logic               active_c;

    // Wait counter reached the limit; a zero limit never trips.
    assign tmo_hit_c = (TIMEOUT != 0) && (wait_q == TMO_W'(TIMEOUT));

    // Counted cycles are those spent executing an instruction.
    assign active_c = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_MEM)   || (state_q == ST_WB);

    // Next-state, wait-counter and strobe decode.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d = ST_FETCH;
                    wait_d  = '0;
                end
            end
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmo_hit_c) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end
            ST_DECODE: begin
                if (bus.ecall_break) begin
                    state_d = ST_HALT;
                end else if (bus.is_load && bus.is_store) begin
                    state_d = ST_ERR;
                end else if (bus.is_load || bus.is_store) begin
                    state_d = ST_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = bus.is_store;
                if (bus.dmem_ack) begin
                    state_d = ST_WB;
                end else if (tmo_hit_c) begin
                    state_d = ST_ERR;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end
            ST_WB: begin
                pc_we_c = 1'b1;
                rf_we_c = bus.reg_write && !bus.is_store;
                if (bus.run) begin
                    state_d = ST_FETCH;
                    wait_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, wait counter and debug counters.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (active_c) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
            if (state_q == ST_WB) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign bus.imem_req = imem_req_c;
    assign bus.ir_we    = ir_we_c;
    assign bus.dmem_req = dmem_req_c;
    assign bus.dmem_we  = dmem_we_c;
    assign bus.rf_we    = rf_we_c;
    assign bus.pc_we    = pc_we_c;
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.bus_err  = (state_q == ST_ERR);
    assign bus.state    = state_q;
    assign bus.cycles   = cycles_q;
    assign bus.instret  = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: each instruction is described as a
// transaction (kind, fetch wait, data wait, run after WB) and the expected
// per-cycle outputs and counters are derived from that description.
module tb_core_sequencer;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned TMO_W    = 8;
    localparam int unsigned TMO      = 4;
    localparam logic [31:0] CNT_MASK = (32'd1 << CNT_W) - 32'd1;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM = 3,
                   S_WB = 4, S_HALT = 5, S_ERR = 6;
    // Instruction kinds
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_ECALL = 3, K_BAD = 4;

    logic clk;
    logic reset_l;
    core_sequencer_if #(.CNT_W(CNT_W)) bus ();

    core_sequencer #(.CNT_W(CNT_W), .TMO_W(TMO_W), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;
    int exp_cyc;
    int exp_ret;

    logic [10:0] obs;
    assign obs = {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
                  bus.rf_we, bus.pc_we, bus.halted, bus.bus_err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic logic [10:0] mk(input int st, input logic ireq, input logic irwe,
                                       input logic dreq, input logic dwe, input logic rfwe,
                                       input logic pcwe);
        return {3'(st), ireq, irwe, dreq, dwe, rfwe, pcwe, st == S_HALT, st == S_ERR};
    endfunction

    // Random values on every input; callers override what matters this cycle.
    task automatic noise();
        bus.run         = 1'($urandom_range(0, 1));
        bus.imem_ack    = 1'($urandom_range(0, 1));
        bus.dmem_ack    = 1'($urandom_range(0, 1));
        bus.is_load     = 1'($urandom_range(0, 1));
        bus.is_store    = 1'($urandom_range(0, 1));
        bus.reg_write   = 1'($urandom_range(0, 1));
        bus.ecall_break = 1'($urandom_range(0, 1));
    endtask

    task automatic set_dec(input int kind, input bit rw);
        bus.reg_write   = rw;
        bus.ecall_break = (kind == K_ECALL);
        if (kind != K_ECALL) begin
            bus.is_load  = (kind == K_LOAD) || (kind == K_BAD);
            bus.is_store = (kind == K_STORE) || (kind == K_BAD);
        end
    endtask

    // Called at a falling edge with inputs driven: check outputs and counters,
    // account for this cycle in the model, advance to the next falling edge.
    task automatic step(input string tag, input logic [10:0] want);
        #1;
        chk({tag, "_out"}, 32'(obs), 32'(want));
        chk({tag, "_cycles"}, 32'(bus.cycles), 32'(exp_cyc) & CNT_MASK);
        chk({tag, "_instret"}, 32'(bus.instret), 32'(exp_ret) & CNT_MASK);
        if (int'(want[10:8]) inside {S_FETCH, S_DECODE, S_MEM, S_WB}) exp_cyc++;
        if (int'(want[10:8]) == S_WB) exp_ret++;
        @(negedge clk);
    endtask

    task automatic idle(input bit run_v);
        noise();
        bus.run = run_v;
        step("idle", mk(S_IDLE, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic stuck(input int st, input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            step(st == S_HALT ? "halt" : "err", mk(st, 0, 0, 0, 0, 0, 0));
        end
    endtask

    // Synchronous reset, then one checked IDLE cycle showing the reset state.
    task automatic do_reset();
        noise();
        reset_l = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        exp_cyc = 0;
        exp_ret = 0;
        idle(1'b0);
    endtask

    // One instruction starting in FETCH; wi/wd are cycles before the ack.
    task automatic run_instr(input int kind, input bit rw, input int wi, input int wd,
                             input bit run_after, output int nxt);
        bit acked;
        acked = 1'b0;
        for (int k = 0; k <= int'(TMO) && !acked; k++) begin
            noise();
            bus.imem_ack = (k == wi);
            step("fetch", mk(S_FETCH, 1, k == wi, 0, 0, 0, 0));
            acked = (k == wi);
        end
        if (!acked) begin
            nxt = S_ERR;
            return;
        end
        noise();
        set_dec(kind, rw);
        step("decode", mk(S_DECODE, 0, 0, 0, 0, 0, 0));
        if (kind == K_ECALL) begin
            nxt = S_HALT;
            return;
        end
        if (kind == K_BAD) begin
            nxt = S_ERR;
            return;
        end
        if (kind == K_LOAD || kind == K_STORE) begin
            acked = 1'b0;
            for (int k = 0; k <= int'(TMO) && !acked; k++) begin
                noise();
                set_dec(kind, rw);
                bus.dmem_ack = (k == wd);
                step("mem", mk(S_MEM, 0, 0, 1, kind == K_STORE, 0, 0));
                acked = (k == wd);
            end
            if (!acked) begin
                nxt = S_ERR;
                return;
            end
        end
        noise();
        set_dec(kind, rw);
        bus.run = run_after;
        step("wb", mk(S_WB, 0, 0, 0, 0, rw && (kind != K_STORE), 1));
        nxt = run_after ? S_FETCH : S_IDLE;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int mode;
        int kind;
        int wi;
        int wd;
        n_checks = 0;
        n_pass   = 0;
        exp_cyc  = 0;
        exp_ret  = 0;
        reset_l  = 1'b0;
        noise();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // ALU with immediate fetch ack, continuing to the next fetch
        idle(1'b1);
        run_instr(K_ALU, 1'b1, 0, 0, 1'b1, nxt);
        chk("alu_next", 32'(nxt), 32'(S_FETCH));
        chk("alu_instret", 32'(bus.instret), 32'd1);
        run_instr(K_ALU, 1'b0, 1, 0, 1'b0, nxt);

        // Load with three data wait cycles from a fresh reset
        do_reset();
        idle(1'b1);
        run_instr(K_LOAD, 1'b1, 0, 3, 1'b0, nxt);
        chk("load_cycles", 32'(bus.cycles), 32'd7);

        // Store
        idle(1'b1);
        run_instr(K_STORE, 1'b1, 2, 1, 1'b0, nxt);
        chk("store_instret", 32'(bus.instret), 32'd2);

        // ecall -> HALT with frozen counters, then reset
        idle(1'b1);
        run_instr(K_ECALL, 1'b1, 0, 0, 1'b1, nxt);
        stuck(S_HALT, 4);
        do_reset();

        // Fetch never acked -> ERR; ack on the last allowed cycle still wins
        idle(1'b1);
        run_instr(K_ALU, 1'b1, 99, 0, 1'b1, nxt);
        stuck(S_ERR, 3);
        do_reset();
        idle(1'b1);
        run_instr(K_ALU, 1'b1, int'(TMO), 0, 1'b0, nxt);
        chk("late_ack_next", 32'(nxt), 32'(S_IDLE));
        idle(1'b1);
        run_instr(K_LOAD, 1'b1, 0, 99, 1'b0, nxt);
        stuck(S_ERR, 2);

        // 16 instructions wrap the 4-bit retired counter, then stop
        do_reset();
        idle(1'b1);
        for (int i = 0; i < 16; i++) begin
            run_instr(K_ALU, 1'b1, 0, 0, i < 15, nxt);
        end
        chk("instret_wrap", 32'(bus.instret), 32'd0);
        idle(1'b0);
        idle(1'b0);

        // Random instruction stream
        mode = S_IDLE;
        for (int n = 0; n < 200; n++) begin
            if (mode == S_IDLE) begin
                idle(1'($urandom_range(0, 2) != 0));
                mode = bus.run ? S_FETCH : S_IDLE;
            end else if (mode == S_FETCH) begin
                case ($urandom_range(0, 19))
                    0:       kind = K_ECALL;
                    1:       kind = K_BAD;
                    2, 3, 4, 5, 6:  kind = K_LOAD;
                    7, 8, 9, 10, 11: kind = K_STORE;
                    default: kind = K_ALU;
                endcase
                wi = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
                wd = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
                run_instr(kind, 1'($urandom_range(0, 1)), wi, wd, 1'($urandom_range(0, 3) != 0), nxt);
                mode = nxt;
            end else begin
                stuck(mode, int'($urandom_range(1, 3)));
                do_reset();
                mode = S_IDLE;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
